mesm6_ifetch: RTL and testbench

- Parametrised instruction prefetch unit for the MESM-6 core. It replaces the single-word opcode cache and pc_cached compare with a DEPTH-word prefetch queue.
- It drives the instruction memory bus on its own and presents 24-bit half-word opcodes, in order, to the microcode sequencer.
- A flush (jump, interrupt entry, reset vector) redirects the stream to a new half-word PC.

---
 rtl/mesm6_pkg.sv | 23 ++
 rtl/mesm6_ifetch_if.sv | 26 ++
 rtl/mesm6_ifetch_fifo.sv | 43 ++++
 rtl/mesm6_ifetch.sv | 138 +++++++++++++
 tb/tb_mesm6_ifetch.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesm6_pkg.sv
// Shared MESM-6 types for the instruction prefetch unit.
package mesm6_pkg;

  typedef logic [47:0] word_t;
  typedef logic [23:0] opcode_t;
  typedef logic [14:0] waddr_t;
  typedef logic [15:0] hpc_t;

  typedef enum logic [1:0] {
    IFS_IDLE  = 2'd0,
    IFS_FETCH = 2'd1,
    IFS_DRAIN = 2'd2
  } ifetch_state_t;

  // Left half-word is the upper 24 bits of the memory word.
  function automatic opcode_t select_half(input word_t w, input logic half);
    opcode_t r;
    if (half) r = w[23:0];
    else      r = w[47:24];
    return r;
  endfunction

endpackage

// File: rtl/mesm6_ifetch_if.sv
// Sequencer-side opcode stream, flush redirect and instruction bus of the prefetch unit.
interface mesm6_ifetch_if;
  import mesm6_pkg::*;

  logic    flush;
  hpc_t    flush_pc;
  logic    op_valid;
  logic    op_ready;
  opcode_t opcode;
  hpc_t    op_pc;
  logic    ibus_fetch;
  waddr_t  ibus_addr;
  word_t   ibus_input;
  logic    ibus_done;

  modport master (
    input  flush, flush_pc, op_ready, ibus_input, ibus_done,
    output op_valid, opcode, op_pc, ibus_fetch, ibus_addr
  );

  modport slave (
    output flush, flush_pc, op_ready, ibus_input, ibus_done,
    input  op_valid, opcode, op_pc, ibus_fetch, ibus_addr
  );

endinterface

// File: rtl/mesm6_ifetch_fifo.sv
// DEPTH x 48 prefetch queue; clear drops all entries in one cycle.
module mesm6_ifetch_fifo
  import mesm6_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  word_t                  data_i,
  input  logic                   pop_i,
  output word_t                  head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mesm6_ifetch.sv
// MESM-6 instruction prefetch unit: DEPTH-word queue feeding 24-bit half-word opcodes.
// Optional statistics counters are enabled by defining MESM6_IFETCH_STATS_EN.
module mesm6_ifetch
  import mesm6_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter hpc_t        RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           reset,
  mesm6_ifetch_if.master bus
`ifdef MESM6_IFETCH_STATS_EN
  ,
  output logic [31:0]    stat_fetches,
  output logic [31:0]    stat_flushes
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifetch_state_t state_q, state_d;
  waddr_t        fptr_q, fptr_d;
  waddr_t        addr_q, addr_d;
  hpc_t          op_pc_q, op_pc_d;
  logic          half_q, half_d;
  logic          push_s, pop_s, consume_s;
  logic [CW-1:0] count_s, count_after_s;
  word_t         head_s;

  mesm6_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (bus.flush),
    .push_i  (push_s),
    .data_i  (bus.ibus_input),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  // A flush wins over both an arriving word and a consume in the same cycle.
  always_comb begin
    consume_s     = bus.op_valid & bus.op_ready & ~bus.flush;
    push_s        = (state_q == IFS_FETCH) & bus.ibus_done & ~bus.flush;
    pop_s         = consume_s & half_q;
    count_after_s = count_s + CW'(push_s) - CW'(pop_s);
  end

  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    half_d  = half_q;
    op_pc_d = op_pc_q;
    addr_d  = addr_q;

    if (bus.flush) begin
      fptr_d  = bus.flush_pc[15:1];
      half_d  = bus.flush_pc[0];
      op_pc_d = bus.flush_pc;
    end else begin
      if (push_s) fptr_d = fptr_q + 15'd1;
      else        fptr_d = fptr_q;
      if (consume_s) begin
        half_d  = ~half_q;
        op_pc_d = op_pc_q + 16'd1;
      end else begin
        half_d  = half_q;
        op_pc_d = op_pc_q;
      end
    end

    case (state_q)
      IFS_IDLE: begin
        if (bus.flush || (count_s < CW'(DEPTH))) state_d = IFS_FETCH;
        else                                     state_d = IFS_IDLE;
      end
      IFS_FETCH: begin
        if (bus.ibus_done) begin
          if (bus.flush || (count_after_s < CW'(DEPTH))) state_d = IFS_FETCH;
          else                                           state_d = IFS_IDLE;
        end else if (bus.flush) begin
          state_d = IFS_DRAIN;
        end else begin
          state_d = IFS_FETCH;
        end
      end
      IFS_DRAIN: begin
        if (bus.ibus_done) state_d = IFS_FETCH;
        else               state_d = IFS_DRAIN;
      end
      default: state_d = IFS_IDLE;
    endcase

    // The request address is frozen while a request is outstanding.
    if ((state_q == IFS_IDLE) || bus.ibus_done) addr_d = fptr_d;
    else                                        addr_d = addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFS_IDLE;
      fptr_q  <= RESET_PC[15:1];
      addr_q  <= RESET_PC[15:1];
      op_pc_q <= RESET_PC;
      half_q  <= RESET_PC[0];
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
      addr_q  <= addr_d;
      op_pc_q <= op_pc_d;
      half_q  <= half_d;
    end
  end

  assign bus.op_valid   = (count_s != {CW{1'b0}});
  assign bus.opcode     = select_half(head_s, half_q);
  assign bus.op_pc      = op_pc_q;
  assign bus.ibus_fetch = (state_q != IFS_IDLE);
  assign bus.ibus_addr  = addr_q;

`ifdef MESM6_IFETCH_STATS_EN
  logic [31:0] stat_fetches_q, stat_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetches_q <= 32'd0;
      stat_flushes_q <= 32'd0;
    end else begin
      if (push_s)    stat_fetches_q <= stat_fetches_q + 32'd1;
      if (bus.flush) stat_flushes_q <= stat_flushes_q + 32'd1;
    end
  end

  assign stat_fetches = stat_fetches_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_mesm6_ifetch.sv
// Directed bench for mesm6_ifetch: memory responder, consume monitor, hand-computed checks.
module tb_mesm6_ifetch;
  import mesm6_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mesm6_ifetch_if bus_if ();
`ifdef MESM6_IFETCH_STATS_EN
  logic [31:0] stat_fetches, stat_flushes;
`endif

  mesm6_ifetch #(.DEPTH(4), .RESET_PC(16'h0002)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
`ifdef MESM6_IFETCH_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_flushes (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mem_en  = 1'b0;
  int          mem_lat = 1;
  int          mem_wait = 0;
  waddr_t      fetch_log[$];
  logic [39:0] cons_log[$];

  function automatic opcode_t op_l(input waddr_t a);
    return {8'hA0, 1'b0, a};
  endfunction

  function automatic opcode_t op_r(input waddr_t a);
    return {8'hB0, 1'b0, a};
  endfunction

  function automatic word_t mkw(input waddr_t a);
    return {op_l(a), op_r(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_en = 1'b0;
    bus_if.ibus_done = 1'b0;
    bus_if.flush = 1'b0;
    bus_if.op_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    fetch_log.delete();
    cons_log.delete();
  endtask

  task automatic wait_fetch(input string tag);
    int k = 0;
    while (k < 20 && !bus_if.ibus_fetch) begin
      step();
      k++;
    end
    chk(tag, 64'(bus_if.ibus_fetch), 64'd1);
  endtask

  // Memory responder and consume monitor, both acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.op_valid && bus_if.op_ready && !bus_if.flush && !reset)
        cons_log.push_back({bus_if.op_pc, bus_if.opcode});
      if (mem_en) begin
        if (!bus_if.ibus_fetch || reset) begin
          bus_if.ibus_done = 1'b0;
          mem_wait = 0;
        end else if (mem_wait >= mem_lat) begin
          bus_if.ibus_done  = 1'b1;
          bus_if.ibus_input = mkw(bus_if.ibus_addr);
          fetch_log.push_back(bus_if.ibus_addr);
          mem_wait = 0;
        end else begin
          bus_if.ibus_done = 1'b0;
          mem_wait++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus_if.flush = 1'b0;
    bus_if.flush_pc = 16'h0000;
    bus_if.op_ready = 1'b0;
    bus_if.ibus_done = 1'b0;
    bus_if.ibus_input = 48'd0;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_valid", 64'(bus_if.op_valid), 64'd0);
    chk("rst_fetch", 64'(bus_if.ibus_fetch), 64'd0);
    chk("rst_addr", 64'(bus_if.ibus_addr), 64'd1);
    chk("rst_pc", 64'(bus_if.op_pc), 64'd2);

    // Streaming from RESET_PC=2 with one-cycle memory
    do_reset();
    mem_lat = 1;
    mem_en = 1'b1;
    bus_if.op_ready = 1'b1;
    repeat (14) step();
    bus_if.op_ready = 1'b0;
    chk("t1_ncons", 64'(cons_log.size() >= 3), 64'd1);
    chk("t1_op0", 64'(cons_log[0]), {24'd0, 16'd2, op_l(15'd1)});
    chk("t1_op1", 64'(cons_log[1]), {24'd0, 16'd3, op_r(15'd1)});
    chk("t1_op2", 64'(cons_log[2]), {24'd0, 16'd4, op_l(15'd2)});

    // Queue fills with op_ready low, then one popping consume
    do_reset();
    mem_lat = 1;
    mem_en = 1'b1;
    repeat (20) step();
    chk("t2_nfetch", 64'(fetch_log.size()), 64'd4);
    chk("t2_first", 64'(fetch_log[0]), 64'd1);
    chk("t2_last", 64'(fetch_log[3]), 64'd4);
    chk("t2_idle", 64'(bus_if.ibus_fetch), 64'd0);
    chk("t2_valid", 64'(bus_if.op_valid), 64'd1);
    chk("t2_head", 64'(bus_if.opcode), 64'(op_l(15'd1)));
    bus_if.op_ready = 1'b1;
    step();
    step();
    bus_if.op_ready = 1'b0;
    repeat (12) step();
    chk("t2_nfetch2", 64'(fetch_log.size()), 64'd5);
    chk("t2_addr5", 64'(fetch_log[4]), 64'd5);
    chk("t2_idle2", 64'(bus_if.ibus_fetch), 64'd0);
    chk("t2_pc", 64'(bus_if.op_pc), 64'd4);
    chk("t2_head2", 64'(bus_if.opcode), 64'(op_l(15'd2)));

    // Flush during a pending fetch with done delayed
    do_reset();
    wait_fetch("t3_start");
    chk("t3_addr", 64'(bus_if.ibus_addr), 64'd1);
    bus_if.flush = 1'b1;
    bus_if.flush_pc = 16'h0011;
    step();
    bus_if.flush = 1'b0;
    chk("t3_valid", 64'(bus_if.op_valid), 64'd0);
    chk("t3_hold_f", 64'(bus_if.ibus_fetch), 64'd1);
    chk("t3_hold_a0", 64'(bus_if.ibus_addr), 64'd1);
    chk("t3_pc", 64'(bus_if.op_pc), 64'h11);
    step();
    chk("t3_hold_a1", 64'(bus_if.ibus_addr), 64'd1);
    step();
    chk("t3_hold_a2", 64'(bus_if.ibus_addr), 64'd1);
    bus_if.ibus_done = 1'b1;
    bus_if.ibus_input = mkw(15'd1);
    step();
    bus_if.ibus_done = 1'b0;
    chk("t3_discard", 64'(bus_if.op_valid), 64'd0);
    chk("t3_newf", 64'(bus_if.ibus_fetch), 64'd1);
    chk("t3_newaddr", 64'(bus_if.ibus_addr), 64'd8);
    bus_if.ibus_done = 1'b1;
    bus_if.ibus_input = mkw(15'd8);
    step();
    bus_if.ibus_done = 1'b0;
    chk("t3_valid2", 64'(bus_if.op_valid), 64'd1);
    chk("t3_op", 64'(bus_if.opcode), 64'(op_r(15'd8)));
    chk("t3_pc2", 64'(bus_if.op_pc), 64'h11);
    chk("t3_next", 64'(bus_if.ibus_addr), 64'd9);

    // Flush together with ibus_done and op_ready
    bus_if.op_ready = 1'b1;
    bus_if.flush = 1'b1;
    bus_if.flush_pc = 16'h0100;
    bus_if.ibus_done = 1'b1;
    bus_if.ibus_input = mkw(15'd9);
    step();
    bus_if.op_ready = 1'b0;
    bus_if.flush = 1'b0;
    bus_if.ibus_done = 1'b0;
    chk("t4_valid", 64'(bus_if.op_valid), 64'd0);
    chk("t4_pc", 64'(bus_if.op_pc), 64'h100);
    chk("t4_fetch", 64'(bus_if.ibus_fetch), 64'd1);
    chk("t4_addr", 64'(bus_if.ibus_addr), 64'h80);

    // Fetch pointer and op_pc wrap, with a DRAIN of the pending 0x80 request
    bus_if.flush = 1'b1;
    bus_if.flush_pc = 16'hFFFF;
    step();
    bus_if.flush = 1'b0;
    fetch_log.delete();
    mem_lat = 0;
    mem_en = 1'b1;
    repeat (20) step();
    chk("t5_nfetch", 64'(fetch_log.size()), 64'd5);
    chk("t5_drain", 64'(fetch_log[0]), 64'h80);
    chk("t5_top", 64'(fetch_log[1]), 64'h7FFF);
    chk("t5_wrap", 64'(fetch_log[2]), 64'h0);
    chk("t5_valid", 64'(bus_if.op_valid), 64'd1);
    chk("t5_op", 64'(bus_if.opcode), 64'(op_r(15'h7FFF)));
    chk("t5_pc", 64'(bus_if.op_pc), 64'hFFFF);
    bus_if.op_ready = 1'b1;
    step();
    bus_if.op_ready = 1'b0;
    mem_en = 1'b0;
    bus_if.ibus_done = 1'b0;
    chk("t5_pcwrap", 64'(bus_if.op_pc), 64'h0);
    chk("t5_op2", 64'(bus_if.opcode), 64'(op_l(15'h0)));

    // Reset while a request is outstanding
    step();
    step();
    chk("t6_prefetch", 64'(bus_if.ibus_fetch), 64'd1);
    reset = 1'b1;
    step();
    chk("t6_fetch", 64'(bus_if.ibus_fetch), 64'd0);
    chk("t6_valid", 64'(bus_if.op_valid), 64'd0);
    chk("t6_addr", 64'(bus_if.ibus_addr), 64'd1);
    chk("t6_pc", 64'(bus_if.op_pc), 64'd2);
    reset = 1'b0;

`ifdef MESM6_IFETCH_STATS_EN
    do_reset();
    chk("st_rst_f", 64'(stat_fetches), 64'd0);
    chk("st_rst_x", 64'(stat_flushes), 64'd0);
    wait_fetch("st_start");
    bus_if.flush = 1'b1;
    bus_if.flush_pc = 16'h0020;
    step();
    bus_if.flush = 1'b0;
    bus_if.ibus_done = 1'b1;
    bus_if.ibus_input = mkw(15'd1);
    step();
    bus_if.ibus_done = 1'b0;
    mem_lat = 1;
    mem_en = 1'b1;
    repeat (16) step();
    mem_en = 1'b0;
    bus_if.ibus_done = 1'b0;
    bus_if.flush = 1'b1;
    bus_if.flush_pc = 16'h0040;
    step();
    bus_if.flush = 1'b0;
    bus_if.ibus_done = 1'b1;
    bus_if.ibus_input = mkw(15'h20);
    step();
    step();
    bus_if.ibus_done = 1'b0;
    step();
    chk("st_fetches", 64'(stat_fetches), 64'd6);
    chk("st_flushes", 64'(stat_flushes), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
